// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step controller front end.
package step_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_MANUAL     = 2'd0,
        S_AUTO_RUN   = 2'd1,
        S_AUTO_PAUSE = 2'd2
    } state_e;

    localparam int                 SPEED_W       = 4;
    localparam logic [SPEED_W-1:0] SPEED_MIN     = 4'd1;
    localparam logic [SPEED_W-1:0] SPEED_MAX     = 4'd15;
    localparam int                 INTERVAL_BASE = 16;

    // Tick count at which the auto interval (INTERVAL_BASE - speed ticks) completes.
    function automatic logic [SPEED_W-1:0] last_tick(input logic [SPEED_W-1:0] spd);
        return SPEED_W'(INTERVAL_BASE - 1 - int'(spd));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter; emits the clean level and a
// one-cycle pulse on each accepted rising edge of that level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_DONE) begin
            level_d = sync2_q;
            press_d = sync2_q;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/step_controller.sv
// Debounced button front end, saturating speed register and manual/auto/pause
// sequencer that issues one-cycle step pulses to the pattern datapath.
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int BASE_TICK_DIV   = 1200000,
    parameter int SPEED_RESET     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               trig,
    input  logic               spd_up,
    input  logic               spd_down,
    output logic               step,
    output logic [SPEED_W-1:0] speed,
    output logic               mode_led,
    output logic               pause_led,
    output logic [STATE_W-1:0] ctrl_state
);

    localparam int PRE_W    = $clog2(BASE_TICK_DIV);
    localparam int BTN_TRIG = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DN   = 2;
    localparam int BTN_MODE = 3;

    logic [3:0] btn_raw, btn_lvl, btn_prs;
    logic       unused_btn;

    assign btn_raw = {mode, spd_down, spd_up, trig};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[g]),
            .level(btn_lvl[g]),
            .press(btn_prs[g])
        );
    end

    // Only the mode switch needs its level; the buttons only need their presses.
    assign unused_btn = ^{btn_lvl[BTN_DN:BTN_TRIG], btn_prs[BTN_MODE]};

    logic trig_p, up_p, dn_p, mode_lvl;
    assign trig_p   = btn_prs[BTN_TRIG];
    assign up_p     = btn_prs[BTN_UP];
    assign dn_p     = btn_prs[BTN_DN];
    assign mode_lvl = btn_lvl[BTN_MODE];

    state_e             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [3:0]         tick_q, tick_d;
    logic               step_q, step_d;
    logic               mode_led_q, pause_led_q;
    logic               base_tick;

    assign base_tick = (pre_q == PRE_W'(BASE_TICK_DIV - 1));

    always_comb begin
        speed_d = speed_q;
        if (up_p && !dn_p && speed_q != SPEED_MAX) begin
            speed_d = speed_q + SPEED_W'(1);
        end else if (dn_p && !up_p && speed_q != SPEED_MIN) begin
            speed_d = speed_q - SPEED_W'(1);
        end
    end

    // Mode changes are checked before trig so a coincident trig press is dropped.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        pre_d   = pre_q;
        tick_d  = tick_q;
        case (state_q)
            S_MANUAL: begin
                pre_d  = '0;
                tick_d = '0;
                if (mode_lvl) state_d = S_AUTO_RUN;
                else          step_d  = trig_p;
            end
            S_AUTO_RUN: begin
                if (!mode_lvl) begin
                    state_d = S_MANUAL;
                    pre_d   = '0;
                    tick_d  = '0;
                end else begin
                    pre_d = base_tick ? '0 : pre_q + PRE_W'(1);
                    if (base_tick) begin
                        if (tick_q >= last_tick(speed_q)) begin
                            tick_d = '0;
                            step_d = 1'b1;
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end
                    if (trig_p) state_d = S_AUTO_PAUSE;
                end
            end
            S_AUTO_PAUSE: begin
                if (!mode_lvl) begin
                    state_d = S_MANUAL;
                    pre_d   = '0;
                    tick_d  = '0;
                end else if (trig_p) begin
                    state_d = S_AUTO_RUN;
                end
            end
            default: begin
                state_d = S_MANUAL;
                pre_d   = '0;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_MANUAL;
            speed_q     <= SPEED_W'(SPEED_RESET);
            pre_q       <= '0;
            tick_q      <= '0;
            step_q      <= 1'b0;
            mode_led_q  <= 1'b0;
            pause_led_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            pre_q       <= pre_d;
            tick_q      <= tick_d;
            step_q      <= step_d;
            mode_led_q  <= (state_d == S_AUTO_RUN) || (state_d == S_AUTO_PAUSE);
            pause_led_q <= (state_d == S_AUTO_PAUSE);
        end
    end

    assign step       = step_q;
    assign speed      = speed_q;
    assign mode_led   = mode_led_q;
    assign pause_led  = pause_led_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed scenarios plus random soak, every cycle
// compared against a behavioural model of the debounce/speed/sequencing rules.
module tb_step_controller;

    localparam int D   = 4;
    localparam int DIV = 10;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] raw_v = '0;   // {mode, spd_down, spd_up, trig}
    logic       step, mode_led, pause_led;
    logic [3:0] speed;
    logic [1:0] ctrl_state;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   step_t[$];
    logic prev_step = 1'b0;

    // Model state: raw sample history, clean levels/presses, auto sequencing.
    logic [D+2:0] hist [4];
    logic [3:0]   m_lvl, m_prs;
    logic         m_auto, m_paused, m_step;
    int           m_speed, m_run, m_ticks;

    always #5 clk = ~clk;

    step_controller #(
        .DEBOUNCE_CYCLES(D),
        .BASE_TICK_DIV  (DIV),
        .SPEED_RESET    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (raw_v[3]),
        .trig      (raw_v[0]),
        .spd_up    (raw_v[1]),
        .spd_down  (raw_v[2]),
        .step      (step),
        .speed     (speed),
        .mode_led  (mode_led),
        .pause_led (pause_led),
        .ctrl_state(ctrl_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int qat(input int idx);
        return (idx >= 0 && idx < step_t.size()) ? step_t[idx] : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        m_lvl    = '0;
        m_prs    = '0;
        m_auto   = 1'b0;
        m_paused = 1'b0;
        m_step   = 1'b0;
        m_speed  = 1;
        m_run    = 0;
        m_ticks  = 0;
    endtask

    // One clock edge: sequencing acts on the clean signals from the previous
    // edge, then the debounce window absorbs the new raw sample.
    task automatic model_edge();
        logic       tp, up, dn, ml;
        logic [D:0] win;
        tp = m_prs[0]; up = m_prs[1]; dn = m_prs[2]; ml = m_lvl[3];
        m_step = 1'b0;
        if (!m_auto) begin
            if (ml) begin
                m_auto = 1'b1; m_paused = 1'b0; m_run = 0; m_ticks = 0;
            end else begin
                m_step = tp;
            end
        end else if (!ml) begin
            m_auto = 1'b0; m_paused = 1'b0;
        end else if (m_paused) begin
            m_paused = !tp;
        end else begin
            m_run++;
            if (m_run % DIV == 0) begin
                m_ticks++;
                if (m_ticks >= 16 - m_speed) begin
                    m_step  = 1'b1;
                    m_ticks = 0;
                end
            end
            m_paused = tp;
        end
        if (up && !dn)      m_speed = (m_speed < 15) ? m_speed + 1 : 15;
        else if (dn && !up) m_speed = (m_speed > 1)  ? m_speed - 1 : 1;
        // A level flips once D+1 consecutive samples, seen two syncs late, disagree with it.
        for (int i = 0; i < 4; i++) begin
            hist[i]  = {hist[i][D+1:0], raw_v[i]};
            win      = hist[i][D+2:2];
            m_prs[i] = 1'b0;
            if ((&win) && !m_lvl[i]) begin
                m_lvl[i] = 1'b1;
                m_prs[i] = 1'b1;
            end else if (!(|win) && m_lvl[i]) begin
                m_lvl[i] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) model_reset();
        else      model_edge();
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("step", 32'(step), 32'(m_step));
            chk("speed", 32'(speed), m_speed);
            chk("state", 32'(ctrl_state), !m_auto ? 0 : (m_paused ? 2 : 1));
            chk("mode_led", 32'(mode_led), 32'(m_auto));
            chk("pause_led", 32'(pause_led), 32'(m_paused));
            if (step) begin
                chk("step_width", 32'(prev_step), 0);
                step_t.push_back(cyc);
            end
            prev_step = step;
        end else begin
            prev_step = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        raw_v[b] = 1'b1;
        cycles(D + 3);
        raw_v[b] = 1'b0;
        cycles(D + 4);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_step"},      32'(step), 0);
        chk({tag, "_speed"},     32'(speed), 1);
        chk({tag, "_state"},     32'(ctrl_state), 0);
        chk({tag, "_mode_led"},  32'(mode_led), 0);
        chk({tag, "_pause_led"}, 32'(pause_led), 0);
    endtask

    initial begin
        int s, r, n;
        cycles(3);
        chk_reset_outputs("rst");
        rst = 1'b1;
        cycles(500);
        chk("idle_steps", step_t.size(), 0);

        // manual: held trig gives one step 7 cycles after the first sample
        s = cyc + 1;
        raw_v[0] = 1'b1; cycles(20); raw_v[0] = 1'b0; cycles(15);
        chk("trig_steps", step_t.size(), 1);
        chk("trig_latency", qat(0) - s, 7);

        step_t.delete();
        for (int i = 0; i < 6; i++) begin
            raw_v[0] = 1'b1; cycles($urandom_range(1, 3));
            raw_v[0] = 1'b0; cycles($urandom_range(2, 6));
        end
        cycles(10);
        chk("glitch_steps", step_t.size(), 0);

        // speed saturation
        repeat (16) press(1);
        chk("speed_max", 32'(speed), 15);
        repeat (20) press(2);
        chk("speed_min", 32'(speed), 1);
        n = $urandom_range(2, 8);
        repeat (n) press(1);
        chk("speed_rand", 32'(speed), 1 + n);
        raw_v[2:1] = 2'b11; cycles(D + 3); raw_v[2:1] = 2'b00; cycles(D + 4);
        chk("speed_both", 32'(speed), 1 + n);
        repeat (12 - n) press(1);
        chk("speed_13", 32'(speed), 13);

        // mode and trig together: mode wins, auto entered with no step
        step_t.delete();
        s = cyc + 1;
        raw_v[3] = 1'b1; raw_v[0] = 1'b1; cycles(7); raw_v[0] = 1'b0; cycles(13);
        chk("prio_steps", step_t.size(), 0);
        chk("prio_state", 32'(ctrl_state), 1);
        chk("prio_mode_led", 32'(mode_led), 1);
        cycles(80);
        chk("auto_first", qat(0) - s, 37);
        chk("auto_period", qat(1) - qat(0), 30);
        chk("auto_period2", qat(2) - qat(1), 30);

        step_t.delete();
        press(1); press(1);
        cycles(40);
        chk("speed_15", 32'(speed), 15);
        chk("auto_fast", qat(step_t.size() - 1) - qat(step_t.size() - 2), 10);

        // pause at 60 cycles into a 150-cycle interval, resume finishes the rest
        repeat (14) press(2);
        chk("speed_1", 32'(speed), 1);
        raw_v[3] = 1'b0; cycles(12);
        chk("manual_state", 32'(ctrl_state), 0);
        step_t.delete();
        s = cyc + 1;
        raw_v[3] = 1'b1; cycles(60);
        raw_v[0] = 1'b1; cycles(7); raw_v[0] = 1'b0;
        cycles($urandom_range(20, 80));
        chk("pause_led", 32'(pause_led), 1);
        chk("pause_state", 32'(ctrl_state), 2);
        chk("pause_steps", step_t.size(), 0);
        r = cyc + 1;
        raw_v[0] = 1'b1; cycles(7); raw_v[0] = 1'b0;
        cycles(110);
        chk("resume_step", qat(0) - r, 97);
        chk("resume_state", 32'(ctrl_state), 1);

        // asynchronous reset mid-interval
        repeat (8) press(1);
        chk("speed_9", 32'(speed), 9);
        cycles($urandom_range(5, 60));
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        cycles(2);
        rst = 1'b1;
        step_t.delete();
        s = cyc + 1;
        cycles(170);
        chk("post_rst_first", qat(0) - s, 157);
        chk("post_rst_state", 32'(ctrl_state), 1);

        // random soak against the model
        for (int k = 0; k < 250; k++) begin
            raw_v[$urandom_range(0, 3)] = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 14));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
